// File: rtl/xor_checksum_checker_if.sv
// rtl/xor_checksum_checker_if.sv - word stream in, frame check result out
interface xor_checksum_checker_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] inData;
    logic             inValid;
    logic             inLast;
    logic             inReady;
    logic [WIDTH-1:0] xorout;
    logic             done;
    logic             flag;
    logic             err;

    modport master (
        output inData,
        output inValid,
        output inLast,
        input  inReady,
        input  xorout,
        input  done,
        input  flag,
        input  err
    );

    modport slave (
        input  inData,
        input  inValid,
        input  inLast,
        output inReady,
        output xorout,
        output done,
        output flag,
        output err
    );
endinterface

// File: rtl/xor_checksum_checker.sv
// rtl/xor_checksum_checker.sv - folds each frame (checksum word included) into an XOR and reports it
module xor_checksum_checker #(
    parameter int WIDTH     = 32,
    parameter int MAX_WORDS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    xor_checksum_checker_if.slave  bus
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] xorout_q;
    logic             done_q;
    logic             flag_q;
    logic             err_q;
    logic             accept;
    logic             trunc;

    // Ready drops during reset as well as for the single REPORT cycle.
    assign bus.inReady = !rst && (state_q != REPORT);

    always_comb begin
        accept  = bus.inValid && bus.inReady;
        acc_d   = (state_q == IDLE) ? bus.inData : (acc_q ^ bus.inData);
        count_d = (state_q == IDLE) ? CW'(1) : (count_q + CW'(1));
        trunc   = (state_q == ACCUM) && !bus.inLast && (count_d == CW'(MAX_WORDS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            xorout_q <= '0;
            done_q   <= 1'b0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        if (bus.inLast || trunc) begin
                            state_q  <= REPORT;
                            done_q   <= 1'b1;
                            xorout_q <= acc_d;
                            err_q    <= trunc;
                            flag_q   <= (acc_d == '0) && !trunc;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                REPORT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.xorout = xorout_q;
    assign bus.done   = done_q;
    assign bus.flag   = flag_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_xor_checksum_checker.sv
// tb/tb_xor_checksum_checker.sv - directed and randomized frames against a queue-based fold model
module tb_xor_checksum_checker;
    localparam int WIDTH     = 32;
    localparam int MAX_WORDS = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xor_checksum_checker_if #(.WIDTH(WIDTH)) bus();

    xor_checksum_checker #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] frame_q[$];
    bit          in_report = 1'b0;
    logic [31:0] exp_xor   = '0;
    bit          exp_flag  = 1'b0;
    bit          exp_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic close_frame(input bit truncated);
        logic [31:0] f = '0;
        foreach (frame_q[i]) f ^= frame_q[i];
        exp_xor  = f;
        exp_err  = truncated;
        exp_flag = (f == 32'h0) && !truncated;
        frame_q.delete();
    endtask

    // One clock: drive inputs, check ready, clock, advance model, check outputs.
    task automatic cycle(input logic [31:0] d, input bit v, input bit l, output bit acc);
        bit was_rst;
        bit next_report;
        bus.inData  = d;
        bus.inValid = v;
        bus.inLast  = l;
        #1;
        chk("inReady", 32'(bus.inReady), 32'(!in_report && !rst));
        was_rst = rst;
        acc = v && !in_report && !rst;
        @(posedge clk);
        #1;
        next_report = 1'b0;
        if (was_rst) begin
            frame_q.delete();
            exp_xor  = '0;
            exp_flag = 1'b0;
            exp_err  = 1'b0;
        end else if (acc) begin
            frame_q.push_back(d);
            if (l) begin
                close_frame(1'b0);
                next_report = 1'b1;
            end else if (frame_q.size() == MAX_WORDS) begin
                close_frame(1'b1);
                next_report = 1'b1;
            end
        end
        in_report = next_report;
        chk("done",   32'(bus.done), 32'(in_report));
        chk("xorout", bus.xorout,    exp_xor);
        chk("flag",   32'(bus.flag), 32'(exp_flag));
        chk("err",    32'(bus.err),  32'(exp_err));
    endtask

    task automatic send_word(input logic [31:0] d, input bit l);
        bit a;
        do cycle(d, 1'b1, l, a); while (!a);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle($urandom, 1'b0, 1'($urandom_range(0, 1)), a);
    endtask

    task automatic do_reset();
        bit a;
        rst = 1'b1;
        cycle($urandom, 1'b1, 1'b0, a);
        rst = 1'b0;
    endtask

    initial begin
        bit          a;
        logic [31:0] words[$];
        logic [31:0] fold;
        int          len;
        bit          corrupt;

        rst = 1'b1;
        bus.inData  = '0;
        bus.inValid = 1'b0;
        bus.inLast  = 1'b0;
        cycle(32'h0, 1'b0, 1'b0, a);
        rst = 1'b0;
        idle(1);

        // Pass frame, valid held high
        send_word(32'hA5A5A5A5, 1'b0);
        send_word(32'h0F0F0F0F, 1'b0);
        send_word(32'hAAAAAAAA, 1'b1);
        chk("pass_done", 32'(bus.done), 32'd1);
        chk("pass_xor", bus.xorout, 32'h0);
        chk("pass_flag", 32'(bus.flag), 32'd1);

        // Corrupt frame, back-to-back with a held word across REPORT
        send_word(32'hA5A5A5A5, 1'b0);
        send_word(32'h0F0F0F0F, 1'b0);
        send_word(32'hAAAAAAAB, 1'b1);
        chk("corrupt_xor", bus.xorout, 32'h1);
        chk("corrupt_flag", 32'(bus.flag), 32'd0);
        idle(2);

        // Single-word frames
        send_word(32'h0, 1'b1);
        chk("single0_flag", 32'(bus.flag), 32'd1);
        send_word(32'h12345678, 1'b1);
        chk("single1_xor", bus.xorout, 32'h12345678);
        chk("single1_flag", 32'(bus.flag), 32'd0);

        // Truncation, then the 17th word begins a new frame
        for (int i = 0; i < MAX_WORDS; i++) send_word(32'h1, 1'b0);
        chk("trunc_err", 32'(bus.err), 32'd1);
        chk("trunc_flag", 32'(bus.flag), 32'd0);
        chk("trunc_xor", bus.xorout, 32'h0);
        send_word(32'h1, 1'b1);
        chk("after_trunc_err", 32'(bus.err), 32'd0);
        chk("after_trunc_xor", bus.xorout, 32'h1);

        // inLast on the MAX_WORDS-th word is a normal end
        for (int i = 0; i < MAX_WORDS - 1; i++) send_word(32'h3, 1'b0);
        send_word(32'h3, 1'b1);
        chk("max_last_err", 32'(bus.err), 32'd0);

        // Gapped pass frame
        idle(2);
        send_word(32'hA5A5A5A5, 1'b0);
        idle(3);
        send_word(32'h0F0F0F0F, 1'b0);
        idle(1);
        send_word(32'hAAAAAAAA, 1'b1);
        chk("gap_xor", bus.xorout, 32'h0);
        chk("gap_flag", 32'(bus.flag), 32'd1);

        // Reset mid-frame
        send_word(32'hDEADBEEF, 1'b0);
        send_word(32'h01234567, 1'b0);
        do_reset();
        chk("rst_xor", bus.xorout, 32'h0);
        idle(1);
        send_word(32'h5, 1'b0);
        send_word(32'h5, 1'b1);
        chk("rst_frame_flag", 32'(bus.flag), 32'd1);

        // Randomized frames with gaps, corruption and truncation
        for (int fr = 0; fr < 30; fr++) begin
            len     = $urandom_range(1, MAX_WORDS + 4);
            corrupt = ($urandom_range(0, 3) == 0);
            words.delete();
            fold = '0;
            for (int i = 0; i < len - 1; i++) begin
                words.push_back($urandom);
                fold ^= words[i];
            end
            words.push_back(corrupt ? (fold ^ (32'h1 << $urandom_range(0, 31))) : fold);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                send_word(words[i], (len <= MAX_WORDS) && (i == len - 1));
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xor_checksum_checker.md
Name: xor_checksum_checker

Overview:
- Receive-side checker for XOR-checksummed word frames; the transmit side XORs all payload words together and appends the result as the final word.
- The block accepts a frame over a valid/ready stream and folds every word, checksum word included, into a running 32-bit XOR.
- At end of frame it reports the folded value and a zero flag. The flag is 1 when the frame is intact.
- Sits after the ALU datapath as a frame integrity check feeding status logic.

Parameters:
- WIDTH, 32, data word width in bits.
- MAX_WORDS, 16, maximum words per frame including the checksum word; must be at least 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- inData  input  WIDTH  frame word.
- inValid  input  1  inData is valid this cycle.
- inLast  input  1  qualifies the final word (the checksum word) of the frame; sampled only when a word is accepted.
- inReady  output  1  block can accept a word this cycle.
- xorout  output  WIDTH  registered XOR fold of the completed frame.
- done  output  1  one-cycle pulse: xorout, flag and err are valid.
- flag  output  1  1 when the fold equals 0 and err is 0 (frame passes).
- err  output  1  1 when the frame was truncated at MAX_WORDS without inLast.

Behaviour:
- Interface: clk and rst as named above. Reset is synchronous, active-high, on a single clock.
- Reset values: state=IDLE, acc=0, count=0, inReady=0 during the reset cycle, xorout=0, done=0, flag=0, err=0.
- Handshake: a word is accepted on a rising edge where inValid=1 and inReady=1. inReady is combinational from state: 1 in IDLE and ACCUM, 0 in REPORT. When inValid=0 nothing changes; idle gaps mid-frame are allowed.
- State IDLE:
  - On accept: acc<=inData, count<=1.
  - If inLast=1, the single-word frame is complete: go to REPORT.
  - Otherwise go to ACCUM.
- State ACCUM:
  - On accept: acc<=acc^inData, count<=count+1.
  - If inLast=1: go to REPORT with err=0.
  - Else if count+1==MAX_WORDS: go to REPORT with err=1 (truncation).
  - Otherwise stay in ACCUM.
- State REPORT (exactly one cycle):
  - done=1, xorout=final acc, err as latched.
  - flag=(final acc==0) && !err.
  - Next state is IDLE. Any inValid during REPORT is not accepted; the sender holds the word.
- Latency: word with inLast accepted on edge N; done, xorout and flag are high/valid in the cycle after edge N. The next frame's first word can be accepted on edge N+2.
- Output holding:
  - xorout, flag and err hold their values after done until the next REPORT overwrites them.
  - done is 0 in every other cycle.
- Arithmetic: bitwise XOR of WIDTH bits, no carry. count is wide enough to hold MAX_WORDS. Neither count nor acc wraps; truncation forces REPORT first.
- Simultaneous events:
  - inLast on the word that reaches MAX_WORDS is a normal end with err=0.
  - inLast is ignored when inValid=0.
- Reset mid-frame: partial acc and count are discarded, the state returns to IDLE and no done is generated. The first word accepted after reset starts a new frame.
- Truncation: after an err report the block is back in IDLE. The sender's remaining words are treated as a new frame.

Test Plan:
- Pass frame: words 0xA5A5A5A5, 0x0F0F0F0F, 0xAAAAAAAA(inLast), inValid held high -> done one cycle after the last edge, xorout=0x00000000, flag=1, err=0.
- Corrupt frame: same as pass frame but last word 0xAAAAAAAB -> xorout=0x00000001, flag=0, err=0.
- Single-word frame: 0x00000000 with inLast in IDLE -> done after 1 edge, flag=1. Repeat with 0x12345678 -> xorout=0x12345678, flag=0.
- Truncation: 16 words of 0x00000001, inLast never set -> done after the 16th accept, err=1, flag=0, xorout=0x00000000. The 17th word starts a new frame.
- Backpressure/gaps: inValid held high across REPORT -> inReady=0 that cycle and the word is not counted. Insert inValid=0 gaps mid-frame -> result identical to the gapless run.
- Reset mid-frame: 2 words accepted, rst=1 for one cycle, then frame 0x5, 0x5(inLast) -> no done during/after the reset, then done with flag=1, xorout=0.
